fir_mac_ctrl: RTL
=================

Name: fir_mac_ctrl

Overview:
- Sequencer for the FIR multiply-accumulate datapath.
- Accepts one input sample per valid/ready handshake and writes it into the circular delay line.
- Steps the accumulator through TAPS multiply cycles, driving coefficient and delay-line addresses plus the 2-bit accumulator control code.
- Presents the finished sum with a valid/ready output handshake; sits between the sample source, the coefficient/delay RAMs, and the accumulator.

Parameters:
- TAPS, 8, number of filter taps (>=1).
- ADDRBITS, $clog2(TAPS) (minimum 1), width of the coefficient and delay-line addresses.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- sample_valid_in  input  1  new sample available
- sample_ready_out  output  1  controller can accept a sample
- wr_en_out  output  1  write the sample into the delay line at data_addr_out
- data_addr_out  output  ADDRBITS  delay-line address
- coeff_addr_out  output  ADDRBITS  coefficient address
- mac_ctrl_out  output  2  accumulator control code
- out_valid_out  output  1  accumulator holds a complete result
- out_ready_in  input  1  consumer accepts the result
- busy_out  output  1  high in any state except IDLE

Behaviour:
- Control codes come from fir_filter_pkg: MAC_NOP=2'b00, MAC_LOAD=2'b01, MAC_ACC=2'b10, MAC_CLR=2'b11.
- Accumulator behaviour per code: LOAD registers the product; ACC registers the running sum; NOP holds; CLR zeroes. The multiplier is combinational from the addressed RAM words.
- All outputs decode from registered state only (state, tap counter, wptr); there is no combinational input-to-output path.
- Registers: state, tap counter tap[ADDRBITS-1:0], delay-line write pointer wptr[ADDRBITS-1:0].
- Reset: state=IDLE, tap=0, wptr=0.
- Reset output values: sample_ready_out=1, wr_en_out=0, mac_ctrl_out=MAC_NOP, out_valid_out=0, busy_out=0, both addresses 0.
- IDLE:
  - sample_ready_out=1, data_addr_out=wptr, wr_en_out=sample_valid_in is not allowed (no comb path), so the accepted sample's write occurs in WRITE.
  - On sample_valid_in=1, latch and go to WRITE.
- WRITE (1 cycle): wr_en_out=1, data_addr_out=wptr, mac_ctrl_out=NOP; go to LOAD.
- LOAD (1 cycle): mac_ctrl_out=LOAD, coeff_addr_out=0, data_addr_out=wptr; set tap=1.
  - Next state: DONE if TAPS==1, else ACC.
- ACC (TAPS-1 cycles): mac_ctrl_out=ACC, coeff_addr_out=tap, data_addr_out=(wptr-tap) mod TAPS.
  - Address wrap for non-power-of-2 TAPS: if tap>wptr, address = wptr+TAPS-tap.
  - tap increments each cycle; when tap==TAPS-1, go to DONE.
- DONE: out_valid_out=1, mac_ctrl_out=NOP (result held). On out_ready_in=1:
  - wptr <= (wptr==TAPS-1) ? 0 : wptr+1.
  - tap <= 0.
  - go to IDLE.
- Backpressure: DONE holds indefinitely while out_ready_in=0. The accumulator is never disturbed and sample_ready_out stays 0.
- sample_ready_out=1 only in IDLE; sample_valid_in is ignored in every other state.
- Latency: sample accepted at edge N gives WRITE in cycle N+1, LOAD in N+2, ACC in N+3..N+TAPS+1, out_valid_out from cycle N+TAPS+2.
- Throughput: one result per TAPS+3 cycles with out_ready_in tied high.
- Reset mid-operation: immediate return to IDLE with all registers at reset values. The delay line is not cleared.

Optional Feature:
- Macro: FIR_MAC_CLR_ON_DONE_EN.
- Defined: after the DONE handshake, go to state CLEAR for one cycle (mac_ctrl_out=MAC_CLR, busy_out=1, sample_ready_out=0), then IDLE. The accumulator reads 0 between results; throughput becomes TAPS+4.
- Undefined: no CLEAR state; the accumulator retains the last result until the next LOAD.

Test Plan:
- Reset: assert rst_n=0 mid-ACC -> next cycle state IDLE, mac_ctrl_out=00, sample_ready_out=1, wptr=0, out_valid_out=0.
- TAPS=4, first sample, out_ready_in=1 -> cycles 1..6 show:
  - wr_en@addr0
  - LOAD coeff0/data0
  - ACC coeff1/data3
  - ACC coeff2/data2
  - ACC coeff3/data1
  - out_valid_out=1
- Second sample (wptr=1) -> LOAD data1, ACC data 0,3,2; with coefficients {1,2,3,4} and samples x0=5, x1=7, out result 7*1+5*2=17.
- Backpressure: hold out_ready_in=0 for 5 cycles in DONE -> mac_ctrl_out=NOP, sample_ready_out=0 throughout, pulsing sample_valid_in has no effect, result unchanged.
- wptr wrap: 4 samples with TAPS=4 -> wptr returns to 0; 5th sample written at addr0, ACC addresses 3,2,1.
- TAPS=1 build -> WRITE, LOAD, DONE; no ACC cycles; with FIR_MAC_CLR_ON_DONE_EN defined, MAC_CLR appears for exactly one cycle after the handshake.

Source files
------------

// File: rtl/fir_mac_ctrl.sv
// FIR multiply-accumulate sequencer: sample intake, tap stepping over the circular delay line, result handshake.
// Optional build macro FIR_MAC_CLR_ON_DONE_EN adds a one-cycle accumulator clear after each result handshake.

package fir_filter_pkg;
    localparam logic [1:0] MAC_NOP  = 2'b00;
    localparam logic [1:0] MAC_LOAD = 2'b01;
    localparam logic [1:0] MAC_ACC  = 2'b10;
    localparam logic [1:0] MAC_CLR  = 2'b11;
endpackage

module fir_mac_ctrl
    import fir_filter_pkg::*;
#(
    parameter int TAPS     = 8,
    parameter int ADDRBITS = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid_in,
    output logic                sample_ready_out,
    output logic                wr_en_out,
    output logic [ADDRBITS-1:0] data_addr_out,
    output logic [ADDRBITS-1:0] coeff_addr_out,
    output logic [1:0]          mac_ctrl_out,
    output logic                out_valid_out,
    input  logic                out_ready_in,
    output logic                busy_out
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // sample_ready_out and out_valid_out depend only on registered state.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        LOAD  = 3'd2,
        ACC   = 3'd3,
        DONE  = 3'd4,
        CLEAR = 3'd5
    } state_t;

    localparam logic [ADDRBITS-1:0] LAST_TAP = ADDRBITS'(TAPS - 1);
    localparam logic [ADDRBITS-1:0] TAPS_A   = ADDRBITS'(TAPS);
    localparam logic [ADDRBITS-1:0] ONE_A    = ADDRBITS'(1);

    state_t              state;
    logic [ADDRBITS-1:0] tap;
    logic [ADDRBITS-1:0] wptr;
    logic [ADDRBITS-1:0] acc_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tap   <= '0;
            wptr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_valid_in) state <= WRITE;
                end
                WRITE: state <= LOAD;
                LOAD: begin
                    tap   <= ONE_A;
                    state <= (TAPS == 1) ? DONE : ACC;
                end
                ACC: begin
                    if (tap == LAST_TAP) state <= DONE;
                    else                 tap   <= tap + ONE_A;
                end
                DONE: begin
                    if (out_ready_in) begin
                        wptr <= (wptr == LAST_TAP) ? '0 : wptr + ONE_A;
                        tap  <= '0;
`ifdef FIR_MAC_CLR_ON_DONE_EN
                        state <= CLEAR;
`else
                        state <= IDLE;
`endif
                    end
                end
                CLEAR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Newest sample sits at wptr; tap k reads k samples back, wrapping within TAPS entries.
    // Arithmetic is modulo 2**ADDRBITS, which is exact because the true result is below TAPS.
    always_comb begin
        if (tap > wptr) acc_addr = wptr + TAPS_A - tap;
        else            acc_addr = wptr - tap;
    end

    always_comb begin
        sample_ready_out = 1'b0;
        wr_en_out        = 1'b0;
        data_addr_out    = wptr;
        coeff_addr_out   = '0;
        mac_ctrl_out     = MAC_NOP;
        out_valid_out    = 1'b0;
        busy_out         = 1'b1;
        case (state)
            IDLE: begin
                sample_ready_out = 1'b1;
                busy_out         = 1'b0;
            end
            WRITE: wr_en_out = 1'b1;
            LOAD:  mac_ctrl_out = MAC_LOAD;
            ACC: begin
                mac_ctrl_out   = MAC_ACC;
                coeff_addr_out = tap;
                data_addr_out  = acc_addr;
            end
            DONE:    out_valid_out = 1'b1;
            CLEAR:   mac_ctrl_out  = MAC_CLR;
            default: busy_out      = 1'b1;
        endcase
    end

endmodule
